// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder with carry-in, carry-out and signed overflow.
// One CHUNK-bit slice of the carry chain is resolved per stage, behind a valid/ready handshake.

module pipe_adder_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_c
);
    logic [CHUNK:0] w_sum;

    assign w_sum = {1'b0, i_a[CHUNK-1:0]} + {1'b0, i_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, i_c};

    // The operand word rotates right by one chunk per stage, and the new sum chunk
    // enters at the top. After NST stages the word holds the full sum in bit order.
    assign o_a = (i_a >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign o_b = i_b >> CHUNK;
    assign o_c = w_sum[CHUNK];
endmodule

module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4     // WIDTH must be a multiple of CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ic,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             oc,
    output logic             ovf
);
    localparam int NST = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] a;    // remaining operand A chunks, with sum chunks rotated in
        logic [WIDTH-1:0] b;    // remaining operand B chunks
        logic             c;    // carry out of the previous chunk
        logic             ma;   // original operand MSBs, kept for overflow
        logic             mb;
    } stg_t;

    stg_t             r_stg [NST];
    logic [NST-1:0]   r_vld;
    logic             r_ovf;

    stg_t             w_src [NST];
    stg_t             w_nxt [NST];
    logic [WIDTH-1:0] w_a   [NST];
    logic [WIDTH-1:0] w_b   [NST];
    logic             w_c   [NST];
    logic             w_adv;
    logic             w_ovf;

    assign w_adv     = !r_vld[NST-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[NST-1];
    assign out       = r_stg[NST-1].a;
    assign oc        = r_stg[NST-1].c;
    assign ovf       = r_ovf;

    always_comb begin
        w_src[0] = '{a: in1, b: in2, c: ic, ma: in1[WIDTH-1], mb: in2[WIDTH-1]};
        for (int i = 1; i < NST; i++) w_src[i] = r_stg[i-1];
    end

    for (genvar g = 0; g < NST; g++) begin : g_stage
        pipe_adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_stage (
            .i_a (w_src[g].a),
            .i_b (w_src[g].b),
            .i_c (w_src[g].c),
            .o_a (w_a[g]),
            .o_b (w_b[g]),
            .o_c (w_c[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NST; i++) begin
            w_nxt[i] = '{a: w_a[i], b: w_b[i], c: w_c[i], ma: w_src[i].ma, mb: w_src[i].mb};
        end
    end

    // Overflow is resolved as the last stage loads, so it leaves straight from a flop.
    assign w_ovf = (w_src[NST-1].ma == w_src[NST-1].mb) &&
                   (w_a[NST-1][WIDTH-1] != w_src[NST-1].ma);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < NST; i++) r_stg[i] <= '0;
        end else if (w_adv) begin
            r_vld <= NST'({r_vld, in_valid});
            r_ovf <= w_ovf;
            for (int i = 0; i < NST; i++) r_stg[i] <= w_nxt[i];
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed NST=1/NST=2 vectors, random 16-bit stream, mid-flight reset.
// The reference is a plain integer sum with a signed range test for overflow.

module tb_pipe_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // NST = 1
    logic       d4_iv, d4_ir, d4_ic, d4_ov, d4_or, d4_oc, d4_ovf;
    logic [3:0] d4_a, d4_b, d4_o;
    pipe_adder #(.WIDTH(4), .CHUNK(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_iv), .in_ready(d4_ir),
        .in1(d4_a), .in2(d4_b), .ic(d4_ic), .out_valid(d4_ov), .out_ready(d4_or),
        .out(d4_o), .oc(d4_oc), .ovf(d4_ovf));

    // NST = 2
    logic       d8_iv, d8_ir, d8_ic, d8_ov, d8_or, d8_oc, d8_ovf;
    logic [7:0] d8_a, d8_b, d8_o;
    pipe_adder #(.WIDTH(8), .CHUNK(4)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_iv), .in_ready(d8_ir),
        .in1(d8_a), .in2(d8_b), .ic(d8_ic), .out_valid(d8_ov), .out_ready(d8_or),
        .out(d8_o), .oc(d8_oc), .ovf(d8_ovf));

    // NST = 4
    logic        d16_iv, d16_ir, d16_ic, d16_ov, d16_or, d16_oc, d16_ovf;
    logic [15:0] d16_a, d16_b, d16_o;
    pipe_adder #(.WIDTH(16), .CHUNK(4)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d16_iv), .in_ready(d16_ir),
        .in1(d16_a), .in2(d16_b), .ic(d16_ic), .out_valid(d16_ov), .out_ready(d16_or),
        .out(d16_o), .oc(d16_oc), .ovf(d16_ovf));

    // Reference: {oc, ovf, out} for a 16-bit add
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s;
        int          ss;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b} + {16'd0, c};
        ss = int'($signed(a)) + int'($signed(b)) + (c ? 1 : 0);
        ov = (ss > 32767) || (ss < -32768);
        return {s[16], ov, s[15:0]};
    endfunction

    // Starts and ends at a negedge
    task automatic t4(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] eo, input logic eoc, input logic eovf);
        d4_iv = 1'b1; d4_a = a; d4_b = b; d4_ic = c;
        @(negedge clk);
        d4_iv = 1'b0;
        chk("d4_valid", d4_ov, 1'b1);
        chk("d4_sum", {d4_oc, d4_ovf, d4_o}, {eoc, eovf, eo});
    endtask

    task automatic t8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] eo, input logic eoc, input logic eovf);
        d8_iv = 1'b1; d8_a = a; d8_b = b; d8_ic = c;
        @(negedge clk);
        d8_iv = 1'b0;
        chk("d8_lat_early", d8_ov, 1'b0);
        @(negedge clk);
        chk("d8_valid", d8_ov, 1'b1);
        chk("d8_sum", {d8_oc, d8_ovf, d8_o}, {eoc, eovf, eo});
    endtask

    logic [17:0] expq[$];
    logic [17:0] e;
    logic [17:0] prev_out;
    bit          prev_stall;
    bit          forced;
    int          n_acc, cyc, force_cnt, cnt;

    initial begin
        d4_iv = 0; d4_a = 0; d4_b = 0; d4_ic = 0; d4_or = 1;
        d8_iv = 0; d8_a = 0; d8_b = 0; d8_ic = 0; d8_or = 1;
        d16_iv = 0; d16_a = 0; d16_b = 0; d16_ic = 0; d16_or = 1;

        @(negedge clk);
        chk("rst_d4", {d4_ov, d4_o, d4_oc, d4_ovf, d4_ir}, 8'h01);
        chk("rst_d8", {d8_ov, d8_o, d8_oc, d8_ovf, d8_ir}, 12'h001);
        chk("rst_d16", {d16_ov, d16_o, d16_oc, d16_ovf, d16_ir}, 20'h00001);
        rst_n = 1'b1;

        t4(4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0);
        t4(4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0);
        t4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

        t8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        t8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        t8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        t8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random stream with in_valid high and a forced 3-cycle stall
        n_acc = 0; cyc = 0; force_cnt = 0; forced = 0; prev_stall = 0; prev_out = '0;
        while ((n_acc < 100 || expq.size() > 0) && cyc < 3000) begin
            if (prev_stall) chk("stall_hold", {d16_oc, d16_ovf, d16_o}, prev_out);
            d16_iv = (n_acc < 100);
            d16_a  = 16'($urandom);
            d16_b  = 16'($urandom);
            d16_ic = 1'($urandom);
            if (force_cnt > 0) begin
                d16_or = 1'b0; force_cnt--;
            end else if (!forced && n_acc >= 20 && d16_ov) begin
                d16_or = 1'b0; force_cnt = 2; forced = 1;
            end else begin
                d16_or = ($urandom_range(0, 3) != 0);
            end
            #1;
            chk("in_ready", d16_ir, !(d16_ov && !d16_or));
            if (d16_ov && d16_or) begin
                if (expq.size() == 0) begin
                    chk("extra_result", expq.size(), 1);
                end else begin
                    e = expq.pop_front();
                    chk("stream_sum", {d16_oc, d16_ovf, d16_o}, e);
                end
            end
            if (d16_iv && d16_ir) begin
                expq.push_back(ref16(d16_a, d16_b, d16_ic));
                n_acc++;
            end
            prev_stall = d16_ov && !d16_or;
            prev_out   = {d16_oc, d16_ovf, d16_o};
            @(negedge clk);
            cyc++;
        end
        chk("stream_acc", n_acc, 100);
        chk("stream_drained", expq.size(), 0);
        chk("stall_seen", forced, 1'b1);

        // Mid-flight reset
        d16_iv = 1'b0; d16_or = 1'b1;
        @(negedge clk);
        d16_iv = 1'b1; d16_a = 16'hFFFF; d16_b = 16'h8000; d16_ic = 1'b0;
        @(negedge clk);
        d16_a = 16'h1234; d16_b = 16'h1111;
        @(negedge clk);
        d16_a = 16'h0001; d16_b = 16'h0001; d16_ic = 1'b1;
        @(negedge clk);
        d16_iv = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", d16_ov, 1'b1);
        chk("pre_rst_sum", {d16_oc, d16_ovf, d16_o}, ref16(16'hFFFF, 16'h8000, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("rst_async", {d16_ov, d16_o, d16_oc, d16_ovf}, 19'h0);
        chk("rst_in_ready", d16_ir, 1'b1);
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", d16_ov, 1'b0);
        end
        d16_iv = 1'b1; d16_a = 16'h7FFF; d16_b = 16'h0000; d16_ic = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            d16_iv = 1'b0;
            cnt++;
        end while (!d16_ov && cnt < 10);
        chk("rst_latency", cnt, 4);
        chk("post_rst_sum", {d16_oc, d16_ovf, d16_o}, ref16(16'h7FFF, 16'h0000, 1'b1));
        @(negedge clk);
        chk("post_rst_drain", d16_ov, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
